asm18_uart_loader: RTL and testbench

Byte-level command engine between the UART receiver/transmitter pair and the asm18 program memory. It consumes one-cycle-valid bytes from `uart_rx` and parses a small host protocol. It writes or reads 18-bit instruction words through a single synchronous memory port and returns responses through `uart_tx`. It also holds the CPU in reset until the host issues RUN.

---
 rtl/asm18_uart_loader_pkg.sv | 30 +++
 rtl/asm18_uart_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_asm18_uart_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/asm18_uart_loader_pkg.sv
// Shared constants and state type for the asm18 UART program loader.
package asm18_loader_pkg;

  localparam int WORD_W = 18;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_NAK = 8'hEE;

  typedef enum logic [3:0] {
    IDLE,
    GET_ALO,
    GET_AHI,
    GET_CNT,
    WR_B0,
    WR_B1,
    WR_B2,
    WR_STROBE,
    RD_ADDR,
    RD_LATCH,
    TX_BYTE,
    TX_WAIT,
    RESP
  } loader_state_t;

endpackage

// File: rtl/asm18_uart_loader.sv
// Byte-level host command engine: loads/dumps asm18 program memory over
// the UART pair and gates the CPU reset with RUN/HALT.
module asm18_uart_loader
  import asm18_loader_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Rx_DV,
  input  logic [7:0]          i_Rx_Byte,
  output logic                o_Tx_DV,
  output logic [7:0]          o_Tx_Byte,
  input  logic                i_Tx_Done,
  output logic [ADDR_W-1:0]   o_Mem_Addr,
  output logic [WORD_W-1:0]   o_Mem_Wdata,
  output logic                o_Mem_We,
  input  logic [WORD_W-1:0]   i_Mem_Rdata,
  output logic                o_Cpu_Reset,
  output logic                o_Busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CLKS);

  loader_state_t       state_q, state_d;
  logic                cmd_rd_q, cmd_rd_d;
  logic [7:0]          alo_q, alo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          idx_q, idx_d;
  logic                resp_q, resp_d;
  logic [7:0]          rsp_q, rsp_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                arg_state;

  // State and datapath registers; everything returns to its idle value on reset.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      cmd_rd_q  <= 1'b0;
      alo_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      idx_q     <= '0;
      resp_q    <= 1'b0;
      rsp_q     <= '0;
      tx_byte_q <= '0;
      tmo_q     <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_rd_q  <= cmd_rd_d;
      alo_q     <= alo_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      idx_q     <= idx_d;
      resp_q    <= resp_d;
      rsp_q     <= rsp_d;
      tx_byte_q <= tx_byte_d;
      tmo_q     <= tmo_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Next-state logic: protocol parsing, memory sequencing and transmit handshake.
  always_comb begin
    state_d   = state_q;
    cmd_rd_d  = cmd_rd_q;
    alo_d     = alo_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    resp_d    = resp_q;
    rsp_d     = rsp_q;
    tx_byte_d = tx_byte_q;
    tmo_d     = '0;
    cpu_rst_d = cpu_rst_q;

    arg_state = (state_q == GET_ALO) || (state_q == GET_AHI) || (state_q == GET_CNT) ||
                (state_q == WR_B0)   || (state_q == WR_B1)   || (state_q == WR_B2);

    // Idle gap counting; an arriving byte takes priority and leaves the counter cleared.
    if (arg_state && !i_Rx_DV) begin
      if (tmo_q == TMO_MAX) begin
        rsp_d   = RSP_NAK;
        state_d = RESP;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (i_Rx_DV) begin
          case (i_Rx_Byte)
            CMD_WRITE, CMD_READ: begin
              if (cpu_rst_q) begin
                cmd_rd_d = (i_Rx_Byte == CMD_READ);
                state_d  = GET_ALO;
              end else begin
                rsp_d   = RSP_NAK;
                state_d = RESP;
              end
            end
            CMD_RUN: begin
              cpu_rst_d = 1'b0;
              rsp_d     = RSP_ACK;
              state_d   = RESP;
            end
            CMD_HALT: begin
              cpu_rst_d = 1'b1;
              rsp_d     = RSP_ACK;
              state_d   = RESP;
            end
            default: begin
              rsp_d   = RSP_NAK;
              state_d = RESP;
            end
          endcase
        end
      end
      GET_ALO: if (i_Rx_DV) begin
        alo_d   = i_Rx_Byte;
        state_d = GET_AHI;
      end
      GET_AHI: if (i_Rx_DV) begin
        addr_d  = ADDR_W'({i_Rx_Byte, alo_q});
        state_d = GET_CNT;
      end
      GET_CNT: if (i_Rx_DV) begin
        cnt_d   = (i_Rx_Byte == 8'h00) ? 9'd256 : {1'b0, i_Rx_Byte};
        state_d = cmd_rd_q ? RD_ADDR : WR_B0;
      end
      WR_B0: if (i_Rx_DV) begin
        wdata_d[7:0] = i_Rx_Byte;
        state_d      = WR_B1;
      end
      WR_B1: if (i_Rx_DV) begin
        wdata_d[15:8] = i_Rx_Byte;
        state_d       = WR_B2;
      end
      WR_B2: if (i_Rx_DV) begin
        wdata_d[17:16] = i_Rx_Byte[1:0];
        state_d        = WR_STROBE;
      end
      WR_STROBE: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          rsp_d   = RSP_ACK;
          state_d = RESP;
        end else begin
          state_d = WR_B0;
        end
      end
      RD_ADDR: state_d = RD_LATCH;
      RD_LATCH: begin
        rdata_d   = i_Mem_Rdata;
        tx_byte_d = i_Mem_Rdata[7:0];
        idx_d     = 2'd0;
        resp_d    = 1'b0;
        state_d   = TX_BYTE;
      end
      TX_BYTE: state_d = TX_WAIT;
      // Return point after a byte completes: resp_q marks the final response,
      // otherwise idx_q selects the next read-word byte.
      TX_WAIT: begin
        if (i_Tx_Done) begin
          if (resp_q) begin
            resp_d  = 1'b0;
            state_d = IDLE;
          end else begin
            case (idx_q)
              2'd0: begin
                idx_d     = 2'd1;
                tx_byte_d = rdata_q[15:8];
                state_d   = TX_BYTE;
              end
              2'd1: begin
                idx_d     = 2'd2;
                tx_byte_d = {6'b0, rdata_q[17:16]};
                state_d   = TX_BYTE;
              end
              default: begin
                idx_d  = 2'd0;
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                  rsp_d   = RSP_ACK;
                  state_d = RESP;
                end else begin
                  state_d = RD_ADDR;
                end
              end
            endcase
          end
        end
      end
      RESP: begin
        tx_byte_d = rsp_q;
        resp_d    = 1'b1;
        state_d   = TX_BYTE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_Tx_DV     = (state_q == TX_BYTE);
  assign o_Tx_Byte   = tx_byte_q;
  assign o_Mem_Addr  = addr_q;
  assign o_Mem_Wdata = wdata_q;
  assign o_Mem_We    = (state_q == WR_STROBE);
  assign o_Cpu_Reset = cpu_rst_q;
  assign o_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_asm18_uart_loader.sv
// Self-checking bench for asm18_uart_loader: UART-tx handshake model,
// synchronous 1024x18 RAM, table of command vectors and corner sequences.
module tb_asm18_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        model_done;
  logic        extra_done = 1'b0;
  logic [9:0]  mem_addr;
  logic [17:0] mem_wdata;
  logic        mem_we;
  logic [17:0] mem_rdata;
  logic        cpu_rst;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hs_err = 0;
  int we_wide = 0;
  int we_count = 0;

  logic [7:0]  txq[$];
  logic [17:0] mem [1024];
  logic        tx_busy;
  int          tx_cnt;
  logic        we_prev;

  assign tx_done = model_done | extra_done;

  always #5 clk = ~clk;

  asm18_uart_loader #(.ADDR_W(10), .TIMEOUT_CLKS(40)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Done   (tx_done),
    .o_Mem_Addr  (mem_addr),
    .o_Mem_Wdata (mem_wdata),
    .o_Mem_We    (mem_we),
    .i_Mem_Rdata (mem_rdata),
    .o_Cpu_Reset (cpu_rst),
    .o_Busy      (busy)
  );

  // Transmitter model: captures each pulsed byte, reports done 4 cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy    <= 1'b0;
      model_done <= 1'b0;
      tx_cnt     <= 0;
    end else begin
      if (tx_dv) begin
        if (tx_busy) hs_err++;
        txq.push_back(tx_byte);
        tx_busy    <= 1'b1;
        tx_cnt     <= 4;
        model_done <= 1'b0;
      end else if (model_done) begin
        model_done <= 1'b0;
        tx_busy    <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt == 1) model_done <= 1'b1;
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  // Program RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count++;
    end
    if (mem_we && we_prev) we_wide++;
    we_prev   <= mem_we;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int budget = 600;
    while (txq.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      errors++;
      checks++;
      $display("FAIL wait_resp: got %0d bytes expected %0d", txq.size(), n);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_dv"},   {31'b0, tx_dv},   32'd0);
    check({tag, "_tx_byte"}, {24'b0, tx_byte}, 32'd0);
    check({tag, "_addr"},    {22'b0, mem_addr}, 32'd0);
    check({tag, "_wdata"},   {14'b0, mem_wdata}, 32'd0);
    check({tag, "_we"},      {31'b0, mem_we},  32'd0);
    check({tag, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
    check({tag, "_busy"},    {31'b0, busy},    32'd0);
  endtask

  typedef struct {
    string        name;
    int           nb;
    logic [95:0]  bin;   // bytes left-aligned, first byte in [95:88]
    int           ne;
    logic [63:0]  ein;   // expected response bytes, left-aligned
    logic         cpu;
    int           wen;
  } vec_t;

  function automatic vec_t mk(input string nm, input int nb, input logic [95:0] bin,
                              input int ne, input logic [63:0] ein, input logic cpu, input int wen);
    vec_t v;
    v.name = nm; v.nb = nb; v.bin = bin; v.ne = ne; v.ein = ein; v.cpu = cpu; v.wen = wen;
    return v;
  endfunction

  vec_t tv[13];

  initial begin
    int we0;
    int budget;
    tv[0]  = mk("run",        1, 96'h03_00000000000000000000_00, 1, 64'hA5_00000000000000, 1'b0, 0);
    tv[1]  = mk("wr_running", 1, 96'h01_00000000000000000000_00, 1, 64'hEE_00000000000000, 1'b0, 0);
    tv[2]  = mk("halt",       1, 96'h04_00000000000000000000_00, 1, 64'hA5_00000000000000, 1'b1, 0);
    tv[3]  = mk("write2",    10, 96'h01_10_00_02_34_12_03_FF_FF_FF_00_00, 1, 64'hA5_00000000000000, 1'b1, 2);
    tv[4]  = mk("read2",      4, 96'h02_10_00_02_0000000000000000, 7, 64'h34_12_03_FF_FF_03_A5_00, 1'b1, 0);
    tv[5]  = mk("wr_wrap",   10, 96'h01_FF_03_02_11_22_01_33_44_02_00_00, 1, 64'hA5_00000000000000, 1'b1, 2);
    tv[6]  = mk("rd_wrap",    4, 96'h02_FF_03_02_0000000000000000, 7, 64'h11_22_01_33_44_02_A5_00, 1'b1, 0);
    tv[7]  = mk("bad_7f",     1, 96'h7F_00000000000000000000_00, 1, 64'hEE_00000000000000, 1'b1, 0);
    tv[8]  = mk("bad_00",     1, 96'h00_00000000000000000000_00, 1, 64'hEE_00000000000000, 1'b1, 0);
    tv[9]  = mk("rd_hi_bits", 4, 96'h02_FF_FF_01_0000000000000000, 4, 64'h11_22_01_A5_00000000, 1'b1, 0);
    tv[10] = mk("run2",       1, 96'h03_00000000000000000000_00, 1, 64'hA5_00000000000000, 1'b0, 0);
    tv[11] = mk("rd_running", 1, 96'h02_00000000000000000000_00, 1, 64'hEE_00000000000000, 1'b0, 0);
    tv[12] = mk("halt2",      1, 96'h04_00000000000000000000_00, 1, 64'hA5_00000000000000, 1'b1, 0);

    for (int i = 0; i < 1024; i++) mem[i] = 18'h0;

    repeat (3) @(negedge clk);
    check_reset_vals("init");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      txq.delete();
      we0 = we_count;
      for (int i = 0; i < tv[v].nb; i++) begin
        send_byte(tv[v].bin[95-8*i -: 8]);
        repeat (2) @(negedge clk);
      end
      wait_resp(tv[v].ne);
      check({tv[v].name, "_len"}, txq.size(), tv[v].ne);
      for (int i = 0; i < tv[v].ne; i++)
        check({tv[v].name, "_byte"}, (i < txq.size()) ? {24'b0, txq[i]} : 32'hFFFF_FFFF,
              {24'b0, tv[v].ein[63-8*i -: 8]});
      check({tv[v].name, "_cpu_rst"}, {31'b0, cpu_rst}, {31'b0, tv[v].cpu});
      check({tv[v].name, "_we_cnt"}, we_count - we0, tv[v].wen);
      check({tv[v].name, "_busy"}, {31'b0, busy}, 32'd0);
    end

    check("mem_010", {14'b0, mem[10'h010]}, 32'h31234);
    check("mem_011", {14'b0, mem[10'h011]}, 32'h3FFFF);
    check("mem_3ff", {14'b0, mem[10'h3FF]}, 32'h12211);
    check("mem_000", {14'b0, mem[10'h000]}, 32'h24433);

    // Write strobe lands exactly in the cycle after the b2 byte.
    txq.delete();
    send_byte(8'h01); repeat (2) @(negedge clk);
    send_byte(8'h20); repeat (2) @(negedge clk);
    send_byte(8'h00); repeat (2) @(negedge clk);
    send_byte(8'h01); repeat (2) @(negedge clk);
    send_byte(8'hAA); repeat (2) @(negedge clk);
    send_byte(8'hBB); repeat (2) @(negedge clk);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h02;
    check("lat_we_before", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rx_dv = 1'b0;
    check("lat_we", {31'b0, mem_we}, 32'd1);
    check("lat_addr", {22'b0, mem_addr}, 32'h020);
    check("lat_wdata", {14'b0, mem_wdata}, 32'h2BBAA);
    @(negedge clk);
    check("lat_we_after", {31'b0, mem_we}, 32'd0);
    wait_resp(1);
    check("lat_ack", (txq.size() > 0) ? {24'b0, txq[0]} : 32'hFFFF_FFFF, 32'hA5);
    check("lat_mem", {14'b0, mem[10'h020]}, 32'h2BBAA);

    // Timeout inside a data word: NAK, nothing written.
    txq.delete();
    we0 = we_count;
    send_byte(8'h01); repeat (2) @(negedge clk);
    send_byte(8'h00); repeat (2) @(negedge clk);
    send_byte(8'h00); repeat (2) @(negedge clk);
    send_byte(8'h01); repeat (2) @(negedge clk);
    send_byte(8'hAA);
    repeat (30) @(negedge clk);
    check("tmo_busy_early", {31'b0, busy}, 32'd1);
    check("tmo_quiet_early", txq.size(), 0);
    wait_resp(1);
    check("tmo_len", txq.size(), 1);
    check("tmo_nak", (txq.size() > 0) ? {24'b0, txq[0]} : 32'hFFFF_FFFF, 32'hEE);
    check("tmo_we_cnt", we_count - we0, 0);
    check("tmo_mem", {14'b0, mem[10'h000]}, 32'h24433);
    check("tmo_busy", {31'b0, busy}, 32'd0);

    // A stray transmit-done while idle must be ignored.
    txq.delete();
    @(negedge clk); extra_done = 1'b1;
    @(negedge clk); extra_done = 1'b0;
    repeat (5) @(negedge clk);
    check("stale_done_busy", {31'b0, busy}, 32'd0);
    check("stale_done_tx", txq.size(), 0);

    // Reset while a READ response is on the wire.
    txq.delete();
    send_byte(8'h02); repeat (2) @(negedge clk);
    send_byte(8'h10); repeat (2) @(negedge clk);
    send_byte(8'h00); repeat (2) @(negedge clk);
    send_byte(8'h02);
    budget = 200;
    while (txq.size() < 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("rst_mid_started", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    txq.delete();
    repeat (3) @(negedge clk);
    send_byte(8'h03);
    wait_resp(1);
    check("post_rst_len", txq.size(), 1);
    check("post_rst_ack", (txq.size() > 0) ? {24'b0, txq[0]} : 32'hFFFF_FFFF, 32'hA5);
    check("post_rst_cpu", {31'b0, cpu_rst}, 32'd0);

    check("tx_handshake", hs_err, 0);
    check("we_one_cycle", we_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
